// File: rtl/vx_raster_dcr_ctx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vx_raster_dcr_ctx_pkg
// Description : Shared raster DCR types. Field widths of raster_dcrs_t, the
//               register index map and register count for the DCR store.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package vx_raster_dcr_ctx_pkg;

    localparam int RASTER_DCR_DATA_BITS = 32;
    localparam int RASTER_ADDR_BITS     = 32;
    localparam int RASTER_TILE_BITS     = 16;
    localparam int RASTER_STRIDE_BITS   = 16;
    localparam int RASTER_DIM_BITS      = 12;

    // Register indices relative to the block's DCR base address
    localparam logic [2:0] RASTER_DCR_TBUF_ADDR   = 3'd0;
    localparam logic [2:0] RASTER_DCR_TILE_COUNT  = 3'd1;
    localparam logic [2:0] RASTER_DCR_PBUF_ADDR   = 3'd2;
    localparam logic [2:0] RASTER_DCR_PBUF_STRIDE = 3'd3;
    localparam logic [2:0] RASTER_DCR_DST_XMIN    = 3'd4;
    localparam logic [2:0] RASTER_DCR_DST_XMAX    = 3'd5;
    localparam logic [2:0] RASTER_DCR_DST_YMIN    = 3'd6;
    localparam logic [2:0] RASTER_DCR_DST_YMAX    = 3'd7;
    localparam int         RASTER_DCR_COUNT       = 8;

    typedef struct packed {
        logic [RASTER_ADDR_BITS-1:0]   tbuf_addr;
        logic [RASTER_TILE_BITS-1:0]   tile_count;
        logic [RASTER_ADDR_BITS-1:0]   pbuf_addr;
        logic [RASTER_STRIDE_BITS-1:0] pbuf_stride;
        logic [RASTER_DIM_BITS-1:0]    dst_xmin;
        logic [RASTER_DIM_BITS-1:0]    dst_xmax;
        logic [RASTER_DIM_BITS-1:0]    dst_ymin;
        logic [RASTER_DIM_BITS-1:0]    dst_ymax;
    } raster_dcrs_t;

endpackage
`default_nettype wire

// File: rtl/vx_raster_dcr_ctx_if.sv
`default_nettype none
// ============================================================================
// Module      : vx_raster_dcr_ctx_if
// Description : Bus bundle for the multi-context raster DCR store.
//               master : host/raster side (drives writes, commit, release)
//               slave  : the DCR context store
// Signals     : dcr_wr_valid/addr/data - DCR write channel
//               commit_valid/ready     - staging snapshot handshake
//               dcrs_valid/dcrs/ctx    - head context to the raster core
//               ctx_release            - free head slot (pulse)
//               count, staged_mask, release_err - status
// Revision    : 1.0 - initial release
// ============================================================================
interface vx_raster_dcr_ctx_if #(
    parameter int NUM_CTX       = 2,
    parameter int DCR_ADDR_BITS = 12
);
    import vx_raster_dcr_ctx_pkg::*;

    localparam int c_ptr_w = $clog2(NUM_CTX);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic                            dcr_wr_valid;
    logic [DCR_ADDR_BITS-1:0]        dcr_wr_addr;
    logic [RASTER_DCR_DATA_BITS-1:0] dcr_wr_data;
    logic                            commit_valid;
    logic                            commit_ready;
    logic                            dcrs_valid;
    raster_dcrs_t                    dcrs;
    logic [c_ptr_w-1:0]              dcrs_ctx;
    logic                            ctx_release;
    logic [c_cnt_w-1:0]              count;
    logic [7:0]                      staged_mask;
    logic                            release_err;

    modport master (
        output dcr_wr_valid, dcr_wr_addr, dcr_wr_data, commit_valid, ctx_release,
        input  commit_ready, dcrs_valid, dcrs, dcrs_ctx, count, staged_mask, release_err
    );

    modport slave (
        input  dcr_wr_valid, dcr_wr_addr, dcr_wr_data, commit_valid, ctx_release,
        output commit_ready, dcrs_valid, dcrs, dcrs_ctx, count, staged_mask, release_err
    );

endinterface
`default_nettype wire

// File: rtl/vx_raster_ctx_ring.sv
`default_nettype none
// ============================================================================
// Module      : vx_raster_ctx_ring
// Description : Pointer/occupancy bookkeeping for a ring of NUM_CTX slots.
//               Push is ignored when full, pop is ignored when empty.
// Ports       : clk, reset (async, active-low)
//               push_i, pop_i         - requests
//               wr_ptr_o, rd_ptr_o    - slot indices
//               count_o               - occupied slots
//               full_o, empty_o       - decoded from count
// Revision    : 1.0 - initial release
// ============================================================================
module vx_raster_ctx_ring #(
    parameter int NUM_CTX = 2
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    input  wire logic                       push_i,
    input  wire logic                       pop_i,
    output logic [$clog2(NUM_CTX)-1:0]      wr_ptr_o,
    output logic [$clog2(NUM_CTX)-1:0]      rd_ptr_o,
    output logic [$clog2(NUM_CTX):0]        count_o,
    output logic                            full_o,
    output logic                            empty_o
);
    localparam int                 c_ptr_w = $clog2(NUM_CTX);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(NUM_CTX);

    logic [c_ptr_w-1:0] r_wr_ptr_q, r_wr_ptr_d;
    logic [c_ptr_w-1:0] r_rd_ptr_q, r_rd_ptr_d;
    logic [c_cnt_w-1:0] r_count_q,  r_count_d;
    logic               w_push, w_pop;

    assign w_push = push_i && (r_count_q != c_full);
    assign w_pop  = pop_i  && (r_count_q != '0);

    // Pointers wrap naturally because NUM_CTX is a power of two
    always_comb begin
        r_wr_ptr_d = r_wr_ptr_q + c_ptr_w'(w_push);
        r_rd_ptr_d = r_rd_ptr_q + c_ptr_w'(w_pop);
        r_count_d  = r_count_q;
        case ({w_push, w_pop})
            2'b10:   r_count_d = r_count_q + 1'b1;
            2'b01:   r_count_d = r_count_q - 1'b1;
            default: r_count_d = r_count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= r_wr_ptr_d;
            r_rd_ptr_q <= r_rd_ptr_d;
            r_count_q  <= r_count_d;
        end
    end

    assign wr_ptr_o = r_wr_ptr_q;
    assign rd_ptr_o = r_rd_ptr_q;
    assign count_o  = r_count_q;
    assign full_o   = (r_count_q == c_full);
    assign empty_o  = (r_count_q == '0);

endmodule
`default_nettype wire

// File: rtl/vx_raster_dcr_ctx.sv
`default_nettype none
// ============================================================================
// Module      : vx_raster_dcr_ctx
// Description : Multi-context raster DCR store. Host writes land in a
//               staging register set; a commit snapshots staging into the
//               next free ring slot. The raster core reads the oldest slot
//               and releases it when its draw completes.
// Ports       : clk   - clock
//               reset - asynchronous, active-low reset
//               bus   - vx_raster_dcr_ctx_if.slave (DCR writes, commit
//                       handshake, head context, release, status)
// Revision    : 1.0 - initial release
// ============================================================================
module vx_raster_dcr_ctx
    import vx_raster_dcr_ctx_pkg::*;
#(
    parameter int NUM_CTX       = 2,
    parameter int DCR_BASE      = 0,
    parameter int DCR_ADDR_BITS = 12
) (
    input  wire logic          clk,
    input  wire logic          reset,
    vx_raster_dcr_ctx_if.slave bus
);
    localparam int                       c_ptr_w = $clog2(NUM_CTX);
    localparam int                       c_cnt_w = c_ptr_w + 1;
    localparam logic [DCR_ADDR_BITS-1:0] c_base  = DCR_ADDR_BITS'(DCR_BASE);
    localparam logic [DCR_ADDR_BITS-1:0] c_nregs = DCR_ADDR_BITS'(RASTER_DCR_COUNT);

    raster_dcrs_t              r_stage_q, r_stage_d;
    logic [7:0]                r_mask_q,  r_mask_d;
    logic                      r_err_q,   r_err_d;
    raster_dcrs_t              r_slot_q [NUM_CTX];

    logic [DCR_ADDR_BITS-1:0]  w_off;
    logic [2:0]                w_idx;
    logic                      w_hit;
    logic                      w_commit_fire;
    logic [NUM_CTX-1:0]        w_slot_we;
    logic [c_ptr_w-1:0]        w_wr_ptr, w_rd_ptr;
    logic [c_cnt_w-1:0]        w_count;
    logic                      w_full, w_empty;

    vx_raster_ctx_ring #(
        .NUM_CTX (NUM_CTX)
    ) u_ring (
        .clk      (clk),
        .reset    (reset),
        .push_i   (w_commit_fire),
        .pop_i    (bus.ctx_release),
        .wr_ptr_o (w_wr_ptr),
        .rd_ptr_o (w_rd_ptr),
        .count_o  (w_count),
        .full_o   (w_full),
        .empty_o  (w_empty)
    );

    // Ready comes from registered occupancy only; a release in the same
    // cycle as a full-ring commit does not let that commit through.
    assign w_commit_fire = bus.commit_valid && !w_full;

    // Address below base wraps to a large offset, but the explicit >= check
    // keeps the intent obvious and safe for any base/width combination.
    assign w_off = bus.dcr_wr_addr - c_base;
    assign w_idx = w_off[2:0];
    assign w_hit = bus.dcr_wr_valid && (bus.dcr_wr_addr >= c_base) && (w_off < c_nregs);

    // Snapshot uses r_stage_q (pre-write). A same-cycle write still marks
    // its mask bit after the commit clears the rest.
    always_comb begin
        r_stage_d = r_stage_q;
        r_mask_d  = w_commit_fire ? 8'h00 : r_mask_q;
        r_err_d   = r_err_q | (bus.ctx_release && w_empty);
        if (w_hit) begin
            r_mask_d[w_idx] = 1'b1;
            case (w_idx)
                RASTER_DCR_TBUF_ADDR:   r_stage_d.tbuf_addr   = RASTER_ADDR_BITS'(bus.dcr_wr_data);
                RASTER_DCR_TILE_COUNT:  r_stage_d.tile_count  = RASTER_TILE_BITS'(bus.dcr_wr_data);
                RASTER_DCR_PBUF_ADDR:   r_stage_d.pbuf_addr   = RASTER_ADDR_BITS'(bus.dcr_wr_data);
                RASTER_DCR_PBUF_STRIDE: r_stage_d.pbuf_stride = RASTER_STRIDE_BITS'(bus.dcr_wr_data);
                RASTER_DCR_DST_XMIN:    r_stage_d.dst_xmin    = RASTER_DIM_BITS'(bus.dcr_wr_data);
                RASTER_DCR_DST_XMAX:    r_stage_d.dst_xmax    = RASTER_DIM_BITS'(bus.dcr_wr_data);
                RASTER_DCR_DST_YMIN:    r_stage_d.dst_ymin    = RASTER_DIM_BITS'(bus.dcr_wr_data);
                default:                r_stage_d.dst_ymax    = RASTER_DIM_BITS'(bus.dcr_wr_data);
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stage_q <= '0;
            r_mask_q  <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_stage_q <= r_stage_d;
            r_mask_q  <= r_mask_d;
            r_err_q   <= r_err_d;
        end
    end

    for (genvar g = 0; g < NUM_CTX; g++) begin : g_slot_we
        assign w_slot_we[g] = w_commit_fire && (w_wr_ptr == c_ptr_w'(g));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CTX; i++) r_slot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CTX; i++) begin
                if (w_slot_we[i]) r_slot_q[i] <= r_stage_q;
            end
        end
    end

    assign bus.commit_ready = !w_full;
    assign bus.dcrs_valid   = !w_empty;
    assign bus.dcrs         = w_empty ? '0 : r_slot_q[w_rd_ptr];
    assign bus.dcrs_ctx     = w_rd_ptr;
    assign bus.count        = w_count;
    assign bus.staged_mask  = r_mask_q;
    assign bus.release_err  = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_raster_dcr_ctx.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_raster_dcr_ctx
// Description : Directed, table-driven bench for vx_raster_dcr_ctx with
//               NUM_CTX=2, DCR_BASE=0x100, plus hand-written sequences for
//               same-cycle commit/write, commit+release and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_raster_dcr_ctx;
    import vx_raster_dcr_ctx_pkg::*;

    localparam int NCTX  = 2;
    localparam int BASE  = 256;
    localparam int ABITS = 12;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    vx_raster_dcr_ctx_if #(.NUM_CTX(NCTX), .DCR_ADDR_BITS(ABITS)) bus ();

    vx_raster_dcr_ctx #(
        .NUM_CTX       (NCTX),
        .DCR_BASE      (BASE),
        .DCR_ADDR_BITS (ABITS)
    ) dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic        cm;
        logic        rl;
        logic [1:0]  e_cnt;
        logic        e_val;
        logic        e_rdy;
        logic [7:0]  e_mask;
        logic [15:0] e_tile;
        logic [31:0] e_tbuf;
        logic        e_ctx;
        logic        e_err;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                         input logic cm, input logic rl);
        @(negedge clk);
        bus.dcr_wr_valid = wr;
        bus.dcr_wr_addr  = addr;
        bus.dcr_wr_data  = data;
        bus.commit_valid = cm;
        bus.ctx_release  = rl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.dcr_wr_valid = 1'b0;
        bus.dcr_wr_addr  = '0;
        bus.dcr_wr_data  = '0;
        bus.commit_valid = 1'b0;
        bus.ctx_release  = 1'b0;
        reset_n = 1'b0;

        //            wr  addr     data          cm  rl  cnt val rdy mask   tile       tbuf          ctx err
        tbl[0]  = '{1, 12'h100, 32'h01234567, 0, 0, 0, 0, 1, 8'h01, 16'h0000, 32'h0,        0, 0};
        tbl[1]  = '{1, 12'h101, 32'h00000005, 0, 0, 0, 0, 1, 8'h03, 16'h0000, 32'h0,        0, 0};
        tbl[2]  = '{0, 12'h000, 32'h0,        1, 0, 1, 1, 1, 8'h00, 16'h0005, 32'h01234567, 0, 0};
        tbl[3]  = '{1, 12'h101, 32'h00012345, 0, 0, 1, 1, 1, 8'h02, 16'h0005, 32'h01234567, 0, 0};
        tbl[4]  = '{0, 12'h000, 32'h0,        1, 0, 2, 1, 0, 8'h00, 16'h0005, 32'h01234567, 0, 0};
        tbl[5]  = '{1, 12'h101, 32'h00000003, 1, 0, 2, 1, 0, 8'h02, 16'h0005, 32'h01234567, 0, 0};
        tbl[6]  = '{0, 12'h000, 32'h0,        1, 1, 1, 1, 1, 8'h02, 16'h2345, 32'h01234567, 1, 0};
        tbl[7]  = '{0, 12'h000, 32'h0,        1, 0, 2, 1, 0, 8'h00, 16'h2345, 32'h01234567, 1, 0};
        tbl[8]  = '{0, 12'h000, 32'h0,        0, 1, 1, 1, 1, 8'h00, 16'h0003, 32'h01234567, 0, 0};
        tbl[9]  = '{0, 12'h000, 32'h0,        0, 1, 0, 0, 1, 8'h00, 16'h0000, 32'h0,        1, 0};
        tbl[10] = '{0, 12'h000, 32'h0,        0, 1, 0, 0, 1, 8'h00, 16'h0000, 32'h0,        1, 1};
        tbl[11] = '{1, 12'h108, 32'h000000FF, 0, 0, 0, 0, 1, 8'h00, 16'h0000, 32'h0,        1, 1};
        tbl[12] = '{1, 12'h0FF, 32'h000000FF, 0, 0, 0, 0, 1, 8'h00, 16'h0000, 32'h0,        1, 1};
        tbl[13] = '{1, 12'h107, 32'h0000000A, 0, 0, 0, 0, 1, 8'h80, 16'h0000, 32'h0,        1, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.count", 64'(bus.count), 64'd0);
        chk("rst.valid", 64'(bus.dcrs_valid), 64'd0);
        chk("rst.ready", 64'(bus.commit_ready), 64'd1);
        chk("rst.mask",  64'(bus.staged_mask), 64'd0);
        chk("rst.err",   64'(bus.release_err), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].cm, tbl[i].rl);
            chk($sformatf("v%0d.count", i), 64'(bus.count),           64'(tbl[i].e_cnt));
            chk($sformatf("v%0d.valid", i), 64'(bus.dcrs_valid),      64'(tbl[i].e_val));
            chk($sformatf("v%0d.ready", i), 64'(bus.commit_ready),    64'(tbl[i].e_rdy));
            chk($sformatf("v%0d.mask",  i), 64'(bus.staged_mask),     64'(tbl[i].e_mask));
            chk($sformatf("v%0d.tile",  i), 64'(bus.dcrs.tile_count), 64'(tbl[i].e_tile));
            chk($sformatf("v%0d.tbuf",  i), 64'(bus.dcrs.tbuf_addr),  64'(tbl[i].e_tbuf));
            chk($sformatf("v%0d.ctx",   i), 64'(bus.dcrs_ctx),        64'(tbl[i].e_ctx));
            chk($sformatf("v%0d.err",   i), 64'(bus.release_err),     64'(tbl[i].e_err));
        end

        // Commit with a same-cycle write to idx7: snapshot holds 10, staging gets 20
        drive(1'b1, 12'h107, 32'd20, 1'b1, 1'b0);
        chk("cw.count", 64'(bus.count), 64'd1);
        chk("cw.ymax",  64'(bus.dcrs.dst_ymax), 64'd10);
        chk("cw.tile",  64'(bus.dcrs.tile_count), 64'd3);
        chk("cw.mask",  64'(bus.staged_mask), 64'h80);
        chk("cw.ctx",   64'(bus.dcrs_ctx), 64'd1);

        // Commit and release together, ring not full: count steady, both advance
        drive(1'b0, 12'h000, 32'd0, 1'b1, 1'b1);
        chk("cr.count", 64'(bus.count), 64'd1);
        chk("cr.ymax",  64'(bus.dcrs.dst_ymax), 64'd20);
        chk("cr.ctx",   64'(bus.dcrs_ctx), 64'd0);
        chk("cr.mask",  64'(bus.staged_mask), 64'h00);

        // Fill ring, dirty staging, then asynchronous reset mid-cycle
        drive(1'b0, 12'h000, 32'd0, 1'b1, 1'b0);
        chk("ar.full",  64'(bus.count), 64'd2);
        drive(1'b1, 12'h102, 32'd7, 1'b0, 1'b0);
        chk("ar.dirty", 64'(bus.staged_mask), 64'h04);
        drive(1'b0, 12'h000, 32'd0, 1'b0, 1'b1);
        chk("ar.err0",  64'(bus.release_err), 64'd1);
        @(negedge clk);
        bus.ctx_release = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar.valid", 64'(bus.dcrs_valid), 64'd0);
        chk("ar.count", 64'(bus.count), 64'd0);
        chk("ar.ready", 64'(bus.commit_ready), 64'd1);
        chk("ar.err",   64'(bus.release_err), 64'd0);
        chk("ar.dcrs",  64'(bus.dcrs == '0), 64'd1);
        chk("ar.mask",  64'(bus.staged_mask), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Staging was cleared by reset: a fresh commit carries all zeros
        drive(1'b0, 12'h000, 32'd0, 1'b1, 1'b0);
        chk("pr.valid", 64'(bus.dcrs_valid), 64'd1);
        chk("pr.dcrs",  64'(bus.dcrs == '0), 64'd1);
        chk("pr.ctx",   64'(bus.dcrs_ctx), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
